// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bp_be_late_wb_arbiter_pkg
//
// Shared types for the late writeback arbiter:
//   bp_be_wb_pkt_s    - writeback packet exchanged between the late producers,
//                       the arbiter and the regfile late write ports
//   wb_pkt_width_lp   - packed width of bp_be_wb_pkt_s
//   bp_be_late_src_e  - round-robin grant encoding (long pipe / memory pipe)
// ----------------------------------------------------------------------------
package bp_be_late_wb_arbiter_pkg;

    localparam int dword_width_gp = 64;
    localparam int reg_addr_width_gp = 5;
    localparam int fflags_width_gp = 5;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic                         late;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

    localparam int wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

    typedef enum logic {
        e_late_src_long = 1'b0,
        e_late_src_mem  = 1'b1
    } bp_be_late_src_e;

endpackage

// File: rtl/bp_be_late_wb_channel.sv
// ----------------------------------------------------------------------------
// bp_be_late_wb_channel
//
// One register class of the late writeback arbiter. Two valid/yumi sources
// (long pipe, memory pipe) compete for a single registered output slot.
// Ties go to the source not granted last; the last-grant bit resets to long,
// so the memory pipe wins the first tie after reset.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   long_pkt_i/_v_i/_yumi_o long pipe source (held by producer until yumi)
//   mem_pkt_i/_v_i/_yumi_o  memory pipe source (held by producer until yumi)
//   pkt_o, v_o              registered output packet and its valid
//   ready_and_i             consumer takes pkt_o this cycle when v_o is high
// ----------------------------------------------------------------------------
module bp_be_late_wb_channel
    import bp_be_late_wb_arbiter_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,

    input  bp_be_wb_pkt_s long_pkt_i,
    input  logic          long_v_i,
    output logic          long_yumi_o,

    input  bp_be_wb_pkt_s mem_pkt_i,
    input  logic          mem_v_i,
    output logic          mem_yumi_o,

    output bp_be_wb_pkt_s pkt_o,
    output logic          v_o,
    input  logic          ready_and_i
);

    logic            full_r;
    bp_be_wb_pkt_s   pkt_r;
    bp_be_late_src_e last_r;

    logic            can_accept;
    logic            accept;
    bp_be_late_src_e grant;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        // Slot is free if empty, or if its current occupant drains this cycle.
        can_accept = !full_r || ready_and_i;
        accept     = !reset_i && can_accept && (long_v_i || mem_v_i);
        if (mem_v_i && (!long_v_i || last_r == e_late_src_long)) begin
            grant = e_late_src_mem;
        end else begin
            grant = e_late_src_long;
        end
    end

    assign long_yumi_o = accept && (grant == e_late_src_long);
    assign mem_yumi_o  = accept && (grant == e_late_src_mem);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_r <= 1'b0;
            last_r <= e_late_src_long;
        end else if (accept) begin
            full_r <= 1'b1;
            last_r <= grant;
        end else if (ready_and_i) begin
            full_r <= 1'b0;
        end
    end

    // NOTE: the packet payload is qualified by full_r, so it carries no reset;
    // this keeps the wide data path free of reset fan-out.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pkt_r <= (grant == e_late_src_mem) ? mem_pkt_i : long_pkt_i;
        end
    end

    assign pkt_o = pkt_r;
    assign v_o   = full_r;

    // Source-side protocol checks: late packets only, and held until consumed.
    a_long_late : assert property (@(posedge clk_i) disable iff (reset_i)
        long_v_i |-> long_pkt_i.late);
    a_mem_late : assert property (@(posedge clk_i) disable iff (reset_i)
        mem_v_i |-> mem_pkt_i.late);
    a_long_hold : assert property (@(posedge clk_i) disable iff (reset_i)
        (long_v_i && !long_yumi_o) |=> long_v_i);
    a_mem_hold : assert property (@(posedge clk_i) disable iff (reset_i)
        (mem_v_i && !mem_yumi_o) |=> mem_v_i);

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// ----------------------------------------------------------------------------
// bp_be_late_wb_arbiter
//
// Consumer end of the late writeback valid/yumi interface. Long pipe
// (divide/sqrt) and memory pipe (late load) writebacks are arbitrated per
// register class and presented as one registered late write per cycle to each
// of the integer and FP register files. The two classes are independent and
// never stall each other.
//
// Ports:
//   clk_i, reset_i                     clock, synchronous active-high reset
//   long_iwb_* / mem_iwb_*             integer late sources (pkt, v, yumi)
//   long_fwb_* / mem_fwb_*             FP late sources (pkt, v, yumi)
//   iwb_pkt_o, iwb_v_o, iwb_ready_and_i  integer regfile late write port
//   fwb_pkt_o, fwb_v_o, fwb_ready_and_i  FP regfile late write port
//   busy_o                             either output register occupied
// ----------------------------------------------------------------------------
module bp_be_late_wb_arbiter
    import bp_be_late_wb_arbiter_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,

    input  bp_be_wb_pkt_s long_iwb_pkt_i,
    input  logic          long_iwb_v_i,
    output logic          long_iwb_yumi_o,

    input  bp_be_wb_pkt_s long_fwb_pkt_i,
    input  logic          long_fwb_v_i,
    output logic          long_fwb_yumi_o,

    input  bp_be_wb_pkt_s mem_iwb_pkt_i,
    input  logic          mem_iwb_v_i,
    output logic          mem_iwb_yumi_o,

    input  bp_be_wb_pkt_s mem_fwb_pkt_i,
    input  logic          mem_fwb_v_i,
    output logic          mem_fwb_yumi_o,

    output bp_be_wb_pkt_s iwb_pkt_o,
    output logic          iwb_v_o,
    input  logic          iwb_ready_and_i,

    output bp_be_wb_pkt_s fwb_pkt_o,
    output logic          fwb_v_o,
    input  logic          fwb_ready_and_i,

    output logic          busy_o
);

    bp_be_wb_pkt_s int_pkt;
    bp_be_wb_pkt_s fp_pkt;

    bp_be_late_wb_channel int_channel (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .long_pkt_i  (long_iwb_pkt_i),
        .long_v_i    (long_iwb_v_i),
        .long_yumi_o (long_iwb_yumi_o),
        .mem_pkt_i   (mem_iwb_pkt_i),
        .mem_v_i     (mem_iwb_v_i),
        .mem_yumi_o  (mem_iwb_yumi_o),
        .pkt_o       (int_pkt),
        .v_o         (iwb_v_o),
        .ready_and_i (iwb_ready_and_i)
    );

    bp_be_late_wb_channel fp_channel (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .long_pkt_i  (long_fwb_pkt_i),
        .long_v_i    (long_fwb_v_i),
        .long_yumi_o (long_fwb_yumi_o),
        .mem_pkt_i   (mem_fwb_pkt_i),
        .mem_v_i     (mem_fwb_v_i),
        .mem_yumi_o  (mem_fwb_yumi_o),
        .pkt_o       (fp_pkt),
        .v_o         (fwb_v_o),
        .ready_and_i (fwb_ready_and_i)
    );

    // Each regfile port only ever performs its own class of write, so the
    // other class's write enables are cleared on the way out. These are
    // constant overrides of register bits; the output stays registered.
    always_comb begin
        iwb_pkt_o            = int_pkt;
        iwb_pkt_o.frd_w_v    = 1'b0;
        iwb_pkt_o.fflags_w_v = 1'b0;

        fwb_pkt_o            = fp_pkt;
        fwb_pkt_o.ird_w_v    = 1'b0;
    end

    assign busy_o = iwb_v_o || fwb_v_o;

    // Register-class checks on the sources.
    a_long_iwb_class : assert property (@(posedge clk_i) disable iff (reset_i)
        long_iwb_v_i |-> long_iwb_pkt_i.ird_w_v);
    a_mem_iwb_class : assert property (@(posedge clk_i) disable iff (reset_i)
        mem_iwb_v_i |-> mem_iwb_pkt_i.ird_w_v);
    a_long_fwb_class : assert property (@(posedge clk_i) disable iff (reset_i)
        long_fwb_v_i |-> long_fwb_pkt_i.frd_w_v);
    a_mem_fwb_class : assert property (@(posedge clk_i) disable iff (reset_i)
        mem_fwb_v_i |-> mem_fwb_pkt_i.frd_w_v);

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bp_be_late_wb_arbiter
//
// Directed bench for bp_be_late_wb_arbiter. Inputs change 1 time unit after
// the rising edge; combinational yumi outputs are checked 1 unit after that,
// registered outputs reflect the previous edge at the same point.
// ----------------------------------------------------------------------------
module tb_bp_be_late_wb_arbiter;
    import bp_be_late_wb_arbiter_pkg::*;

    logic          clk;
    logic          reset_i;

    bp_be_wb_pkt_s long_iwb_pkt_i, long_fwb_pkt_i, mem_iwb_pkt_i, mem_fwb_pkt_i;
    logic          long_iwb_v_i, long_fwb_v_i, mem_iwb_v_i, mem_fwb_v_i;
    logic          long_iwb_yumi_o, long_fwb_yumi_o, mem_iwb_yumi_o, mem_fwb_yumi_o;
    bp_be_wb_pkt_s iwb_pkt_o, fwb_pkt_o;
    logic          iwb_v_o, fwb_v_o, iwb_ready_and_i, fwb_ready_and_i, busy_o;

    int n_checks = 0;
    int n_errors = 0;

    bp_be_late_wb_arbiter dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .long_iwb_pkt_i  (long_iwb_pkt_i),
        .long_iwb_v_i    (long_iwb_v_i),
        .long_iwb_yumi_o (long_iwb_yumi_o),
        .long_fwb_pkt_i  (long_fwb_pkt_i),
        .long_fwb_v_i    (long_fwb_v_i),
        .long_fwb_yumi_o (long_fwb_yumi_o),
        .mem_iwb_pkt_i   (mem_iwb_pkt_i),
        .mem_iwb_v_i     (mem_iwb_v_i),
        .mem_iwb_yumi_o  (mem_iwb_yumi_o),
        .mem_fwb_pkt_i   (mem_fwb_pkt_i),
        .mem_fwb_v_i     (mem_fwb_v_i),
        .mem_fwb_yumi_o  (mem_fwb_yumi_o),
        .iwb_pkt_o       (iwb_pkt_o),
        .iwb_v_o         (iwb_v_o),
        .iwb_ready_and_i (iwb_ready_and_i),
        .fwb_pkt_o       (fwb_pkt_o),
        .fwb_v_o         (fwb_v_o),
        .fwb_ready_and_i (fwb_ready_and_i),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integer source packet. frd_w_v/fflags_w_v are set on purpose so the
    // output-side clearing is visible.
    function automatic bp_be_wb_pkt_s mk_int(input logic [4:0] rd, input logic [63:0] d);
        bp_be_wb_pkt_s p;
        p.ird_w_v    = 1'b1;
        p.frd_w_v    = 1'b1;
        p.late       = 1'b1;
        p.rd_addr    = rd;
        p.rd_data    = d;
        p.fflags_w_v = 1'b1;
        p.fflags     = 5'h1f;
        return p;
    endfunction

    // FP source packet. ird_w_v is set on purpose for the same reason.
    function automatic bp_be_wb_pkt_s mk_fp(input logic [4:0] rd, input logic [63:0] d,
                                            input logic [4:0] fl);
        bp_be_wb_pkt_s p;
        p.ird_w_v    = 1'b1;
        p.frd_w_v    = 1'b1;
        p.late       = 1'b1;
        p.rd_addr    = rd;
        p.rd_data    = d;
        p.fflags_w_v = 1'b1;
        p.fflags     = fl;
        return p;
    endfunction

    function automatic bp_be_wb_pkt_s exp_int(input bp_be_wb_pkt_s p);
        bp_be_wb_pkt_s q = p;
        q.frd_w_v    = 1'b0;
        q.fflags_w_v = 1'b0;
        return q;
    endfunction

    function automatic bp_be_wb_pkt_s exp_fp(input bp_be_wb_pkt_s p);
        bp_be_wb_pkt_s q = p;
        q.ird_w_v = 1'b0;
        return q;
    endfunction

    task automatic idle_inputs();
        long_iwb_v_i = 1'b0;
        long_fwb_v_i = 1'b0;
        mem_iwb_v_i  = 1'b0;
        mem_fwb_v_i  = 1'b0;
        iwb_ready_and_i = 1'b1;
        fwb_ready_and_i = 1'b1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    bp_be_wb_pkt_s pa, pb, pc, pp, pq;
    bp_be_wb_pkt_s lq [8];
    bp_be_wb_pkt_s mq [8];
    bp_be_wb_pkt_s fq [4];
    bp_be_wb_pkt_s expq [16];

    initial begin
        long_iwb_pkt_i = '0;
        long_fwb_pkt_i = '0;
        mem_iwb_pkt_i  = '0;
        mem_fwb_pkt_i  = '0;
        idle_inputs();

        // ---------------- reset state, yumi gated while in reset
        reset_i        = 1'b1;
        long_iwb_pkt_i = mk_int(5'd1, 64'h1);
        mem_fwb_pkt_i  = mk_fp(5'd1, 64'h1, 5'h0);
        long_iwb_v_i   = 1'b1;
        mem_fwb_v_i    = 1'b1;
        #1;
        check("rst_long_iwb_yumi", long_iwb_yumi_o, 1'b0);
        check("rst_mem_fwb_yumi", mem_fwb_yumi_o, 1'b0);
        long_iwb_v_i = 1'b0;
        mem_fwb_v_i  = 1'b0;
        tick();
        reset_i = 1'b0;
        #1;
        check("rst_iwb_v", iwb_v_o, 1'b0);
        check("rst_fwb_v", fwb_v_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);

        // ---------------- single source
        do_reset();
        pa = mk_int(5'd5, 64'h2A);
        long_iwb_pkt_i = pa;
        long_iwb_v_i   = 1'b1;
        #1;
        check("single_long_yumi", long_iwb_yumi_o, 1'b1);
        check("single_mem_yumi", mem_iwb_yumi_o, 1'b0);
        tick();
        long_iwb_v_i = 1'b0;
        #1;
        check("single_iwb_v", iwb_v_o, 1'b1);
        check("single_iwb_pkt", iwb_pkt_o, exp_int(pa));
        check("single_busy", busy_o, 1'b1);
        check("single_no_yumi", long_iwb_yumi_o, 1'b0);
        tick();
        check("single_drained_v", iwb_v_o, 1'b0);
        check("single_drained_busy", busy_o, 1'b0);

        // ---------------- FP tie from reset: mem first, then long
        do_reset();
        pa = mk_fp(5'd3, 64'h3333, 5'h01);
        pb = mk_fp(5'd7, 64'h7777, 5'h10);
        long_fwb_pkt_i = pa;
        mem_fwb_pkt_i  = pb;
        long_fwb_v_i   = 1'b1;
        mem_fwb_v_i    = 1'b1;
        #1;
        check("tie_c0_mem_yumi", mem_fwb_yumi_o, 1'b1);
        check("tie_c0_long_yumi", long_fwb_yumi_o, 1'b0);
        tick();
        mem_fwb_v_i = 1'b0;
        #1;
        check("tie_c1_long_yumi", long_fwb_yumi_o, 1'b1);
        check("tie_c1_fwb_v", fwb_v_o, 1'b1);
        check("tie_c1_fwb_pkt", fwb_pkt_o, exp_fp(pb));
        tick();
        long_fwb_v_i = 1'b0;
        #1;
        check("tie_c2_fwb_pkt", fwb_pkt_o, exp_fp(pa));
        tick();
        check("tie_c3_fwb_v", fwb_v_o, 1'b0);

        // ---------------- back-pressure on the int channel
        do_reset();
        pa = mk_int(5'd9, 64'hAAAA);
        pb = mk_int(5'd10, 64'hBBBB);
        iwb_ready_and_i = 1'b0;
        long_iwb_pkt_i  = pa;
        long_iwb_v_i    = 1'b1;
        #1;
        check("bp_empty_accept", long_iwb_yumi_o, 1'b1);
        tick();
        long_iwb_v_i  = 1'b0;
        mem_iwb_pkt_i = pb;
        mem_iwb_v_i   = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_stall%0d_yumi", i), mem_iwb_yumi_o, 1'b0);
            check($sformatf("bp_stall%0d_v", i), iwb_v_o, 1'b1);
            check($sformatf("bp_stall%0d_pkt", i), iwb_pkt_o, exp_int(pa));
            tick();
        end
        iwb_ready_and_i = 1'b1;
        #1;
        check("bp_refill_yumi", mem_iwb_yumi_o, 1'b1);
        tick();
        mem_iwb_v_i = 1'b0;
        #1;
        check("bp_refill_v", iwb_v_o, 1'b1);
        check("bp_refill_pkt", iwb_pkt_o, exp_int(pb));
        tick();
        check("bp_final_v", iwb_v_o, 1'b0);

        // ---------------- sustained contention, 8 packets per source
        do_reset();
        for (int i = 0; i < 8; i++) begin
            lq[i] = mk_int(5'(i + 1), 64'h100 + 64'(i));
            mq[i] = mk_int(5'(i + 16), 64'h200 + 64'(i));
            expq[2*i]     = exp_int(mq[i]);
            expq[2*i + 1] = exp_int(lq[i]);
        end
        begin
            int li = 0;
            int mi = 0;
            for (int c = 0; c <= 16; c++) begin
                long_iwb_v_i = (li < 8);
                mem_iwb_v_i  = (mi < 8);
                if (li < 8) long_iwb_pkt_i = lq[li];
                if (mi < 8) mem_iwb_pkt_i  = mq[mi];
                #1;
                if (c < 16) begin
                    check($sformatf("rr_c%0d_mem_yumi", c), mem_iwb_yumi_o, (c % 2) == 0);
                    check($sformatf("rr_c%0d_long_yumi", c), long_iwb_yumi_o, (c % 2) == 1);
                end
                if (c >= 1) begin
                    check($sformatf("rr_c%0d_v", c), iwb_v_o, 1'b1);
                    check($sformatf("rr_c%0d_pkt", c), iwb_pkt_o, expq[c-1]);
                end
                if (long_iwb_yumi_o) li++;
                if (mem_iwb_yumi_o)  mi++;
                tick();
            end
            long_iwb_v_i = 1'b0;
            mem_iwb_v_i  = 1'b0;
            #1;
            check("rr_consumed_long", li, 8);
            check("rr_consumed_mem", mi, 8);
            check("rr_final_v", iwb_v_o, 1'b0);
        end

        // ---------------- independence: int stalled, FP streams
        do_reset();
        pc = mk_int(5'd12, 64'hC);
        for (int i = 0; i < 4; i++) fq[i] = mk_fp(5'(i + 1), 64'hF00 + 64'(i), 5'(i + 1));
        iwb_ready_and_i = 1'b0;
        mem_iwb_pkt_i   = pc;
        mem_iwb_v_i     = 1'b1;
        long_fwb_pkt_i  = fq[0];
        long_fwb_v_i    = 1'b1;
        #1;
        check("ind_c0_int_yumi", mem_iwb_yumi_o, 1'b1);
        check("ind_c0_fp_yumi", long_fwb_yumi_o, 1'b1);
        tick();
        mem_iwb_v_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            long_fwb_pkt_i = fq[c];
            #1;
            check($sformatf("ind_c%0d_fp_yumi", c), long_fwb_yumi_o, 1'b1);
            check($sformatf("ind_c%0d_fwb_v", c), fwb_v_o, 1'b1);
            check($sformatf("ind_c%0d_fwb_pkt", c), fwb_pkt_o, exp_fp(fq[c-1]));
            check($sformatf("ind_c%0d_iwb_v", c), iwb_v_o, 1'b1);
            check($sformatf("ind_c%0d_busy", c), busy_o, 1'b1);
            tick();
        end
        long_fwb_v_i    = 1'b0;
        fwb_ready_and_i = 1'b0;
        #1;
        check("ind_c4_fwb_pkt", fwb_pkt_o, exp_fp(fq[3]));
        check("ind_c4_iwb_pkt", iwb_pkt_o, exp_int(pc));

        // ---------------- reset with both registers full, sources pending
        pp = mk_int(5'd20, 64'h2020);
        pq = mk_int(5'd21, 64'h2121);
        long_iwb_pkt_i = pp;
        mem_iwb_pkt_i  = pq;
        long_iwb_v_i   = 1'b1;
        mem_iwb_v_i    = 1'b1;
        reset_i        = 1'b1;
        #1;
        check("rst2_long_yumi", long_iwb_yumi_o, 1'b0);
        check("rst2_mem_yumi", mem_iwb_yumi_o, 1'b0);
        tick();
        reset_i         = 1'b0;
        iwb_ready_and_i = 1'b1;
        fwb_ready_and_i = 1'b1;
        #1;
        check("rst2_iwb_v", iwb_v_o, 1'b0);
        check("rst2_fwb_v", fwb_v_o, 1'b0);
        check("rst2_busy", busy_o, 1'b0);
        check("rst2_tie_mem_yumi", mem_iwb_yumi_o, 1'b1);
        check("rst2_tie_long_yumi", long_iwb_yumi_o, 1'b0);
        tick();
        mem_iwb_v_i = 1'b0;
        #1;
        check("rst2_long_yumi_next", long_iwb_yumi_o, 1'b1);
        check("rst2_iwb_pkt_mem", iwb_pkt_o, exp_int(pq));
        tick();
        long_iwb_v_i = 1'b0;
        #1;
        check("rst2_iwb_pkt_long", iwb_pkt_o, exp_int(pp));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
